// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: opcode constants, fetch FSM states and
// instruction-length width.
package cpu_pkg;

  localparam int NUM_W = 4;

  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_PUSH_EAX = 8'h50;
  localparam logic [7:0] OP_PUSH_EBX = 8'h53;
  localparam logic [7:0] OP_POP_EBP  = 8'h5d;
  localparam logic [7:0] OP_MOV_RR   = 8'h89;
  localparam logic [7:0] OP_MOV_RM   = 8'h8b;
  localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
  localparam logic [7:0] OP_GRP83    = 8'h83;
  localparam logic [7:0] OP_ADD      = 8'h01;
  localparam logic [7:0] OP_PUSH_IMM = 8'h6a;
  localparam logic [7:0] OP_JNE      = 8'h75;
  localparam logic [7:0] OP_JMP      = 8'heb;
  localparam logic [7:0] OP_CALL     = 8'he8;
  localparam logic [7:0] OP_RET      = 8'hc3;
  localparam logic [7:0] OP_LEAVE    = 8'hc9;

  typedef enum logic [1:0] {
    ST_OPC,
    ST_BYTES,
    ST_HOLD,
    ST_DRAIN
  } fetch_st_e;

endpackage

// File: rtl/ilen_decode.sv
// Opcode -> instruction length. Unknown opcodes are reported as illegal
// single-byte instructions so fetch always makes forward progress.
module ilen_decode
  import cpu_pkg::*;
(
  input  logic [7:0]       opcode_i,
  output logic [NUM_W-1:0] len_o,
  output logic             illegal_o
);

  always_comb begin
    len_o     = NUM_W'(1);
    illegal_o = 1'b0;
    case (opcode_i)
      OP_PUSH_EBP, OP_PUSH_EAX, OP_PUSH_EBX, OP_POP_EBP,
      OP_RET, OP_LEAVE:                                   len_o = NUM_W'(1);
      OP_MOV_RR, OP_ADD, OP_PUSH_IMM, OP_JNE, OP_JMP:     len_o = NUM_W'(2);
      OP_MOV_RM, OP_GRP83:                                len_o = NUM_W'(3);
      OP_MOV_IMM, OP_CALL:                                len_o = NUM_W'(5);
      default:                                            illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_align.sv
// Byte-serial instruction fetch: assembles one instruction into a 32-bit
// window and holds it under valid/ready until execute takes it.
module fetch_align
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic [31:0]      ope,
  output logic [NUM_W-1:0] num_of_ope,
  output logic [31:0]      instr_addr,
  output logic             illegal,
  output logic             ope_valid,
  input  logic             ope_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc
);

  fetch_st_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             req_q, req_d;
  logic [31:0]      ope_q, ope_d;
  logic [NUM_W-1:0] len_q, len_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ia_q, ia_d;
  logic             ill_q, ill_d;
  logic             vld_q, vld_d;

  logic [NUM_W-1:0] dec_len;
  logic             dec_ill;

  ilen_decode u_ilen (
    .opcode_i  (mem_rdata),
    .len_o     (dec_len),
    .illegal_o (dec_ill)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    ope_d   = ope_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ia_d    = ia_q;
    ill_d   = ill_q;
    vld_d   = vld_q;
    if (redirect_valid) begin
      pc_d  = redirect_pc;
      vld_d = 1'b0;
      // An unacked read must still be absorbed before the new fetch starts.
      if ((req_q || state_q == ST_DRAIN) && !mem_ack) begin
        req_d   = 1'b0;
        state_d = ST_DRAIN;
      end else begin
        req_d   = 1'b1;
        state_d = ST_OPC;
      end
    end else begin
      case (state_q)
        ST_OPC: begin
          if (!req_q) begin
            req_d = 1'b1;
          end else if (mem_ack) begin
            pc_d  = pc_q + 32'd1;
            ope_d = {mem_rdata, 24'h0};
            ia_d  = pc_q;
            len_d = dec_len;
            ill_d = dec_ill;
            if (dec_len == NUM_W'(1)) begin
              vld_d   = 1'b1;
              req_d   = 1'b0;
              state_d = ST_HOLD;
            end else begin
              cnt_d   = NUM_W'(1);
              state_d = ST_BYTES;
            end
          end
        end
        ST_BYTES: begin
          if (req_q && mem_ack) begin
            pc_d = pc_q + 32'd1;
            // Byte 4 of a 5-byte instruction has no slot and is dropped.
            case (cnt_q)
              NUM_W'(1): ope_d[23:16] = mem_rdata;
              NUM_W'(2): ope_d[15:8]  = mem_rdata;
              NUM_W'(3): ope_d[7:0]   = mem_rdata;
              default: ;
            endcase
            if (cnt_q == len_q - NUM_W'(1)) begin
              vld_d   = 1'b1;
              req_d   = 1'b0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + NUM_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (ope_ready) begin
            vld_d   = 1'b0;
            req_d   = 1'b1;
            state_d = ST_OPC;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            req_d   = 1'b1;
            state_d = ST_OPC;
          end
        end
        default: state_d = ST_OPC;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OPC;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      ope_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ia_q    <= '0;
      ill_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      ope_q   <= ope_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ia_q    <= ia_d;
      ill_q   <= ill_d;
      vld_q   <= vld_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = pc_q;
  assign ope        = ope_q;
  assign num_of_ope = len_q;
  assign instr_addr = ia_q;
  assign illegal    = ill_q;
  assign ope_valid  = vld_q;

endmodule

// File: tb/tb_fetch_align.sv
// Directed and random checks of fetch_align against a byte-memory model and
// an opcode-table reference decoder.
module tb_fetch_align;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] ope;
  logic [3:0]  num_of_ope;
  logic [31:0] instr_addr;
  logic        illegal;
  logic        ope_valid;
  logic        ope_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int errors = 0;
  int checks = 0;

  fetch_align #(.RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ope            (ope),
    .num_of_ope     (num_of_ope),
    .instr_addr     (instr_addr),
    .illegal        (illegal),
    .ope_valid      (ope_valid),
    .ope_ready      (ope_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  // Byte memory: 256 bytes aliased over the address space, one request at a
  // time, acked after mdelay wait cycles; keeps serving a request even if
  // mem_req drops before the ack.
  logic [7:0]  mem [256];
  int          mdelay = 0;
  logic        outst;
  int          wcnt;
  logic [31:0] oaddr;

  always_comb begin
    mem_ack   = (mem_req || outst) && (wcnt >= mdelay);
    mem_rdata = outst ? mem[oaddr[7:0]] : mem[mem_addr[7:0]];
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outst <= 1'b0;
      wcnt  <= 0;
      oaddr <= 32'h0;
    end else if (mem_ack) begin
      outst <= 1'b0;
      wcnt  <= 0;
    end else if (mem_req || outst) begin
      outst <= 1'b1;
      if (!outst) oaddr <= mem_addr;
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the opcode length table.
  task automatic ref_decode(input logic [31:0] a, output logic [31:0] e,
                            output int l, output logic il);
    logic [7:0] op;
    op = mem[a[7:0]];
    il = 1'b0;
    if (op inside {8'h55, 8'h50, 8'h53, 8'h5d, 8'hc3, 8'hc9}) l = 1;
    else if (op inside {8'h89, 8'h01, 8'h6a, 8'h75, 8'heb}) l = 2;
    else if (op inside {8'h8b, 8'h83}) l = 3;
    else if (op inside {8'hb8, 8'he8}) l = 5;
    else begin
      l  = 1;
      il = 1'b1;
    end
    e = {op, 24'h0};
    for (int k = 1; k < l && k <= 3; k++) begin
      logic [31:0] ak;
      ak = a + 32'(k);
      e  = e | ({24'h0, mem[ak[7:0]]} << (24 - 8 * k));
    end
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] a, output int l);
    logic [31:0] e;
    logic        il;
    ref_decode(a, e, l, il);
    chk({tag, ".ope"}, ope, e);
    chk({tag, ".num"}, {28'h0, num_of_ope}, 32'(l));
    chk({tag, ".iaddr"}, instr_addr, a);
    chk({tag, ".ill"}, {31'h0, illegal}, {31'h0, il});
  endtask

  task automatic rst();
    ope_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    reset_n        = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic goto(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_req && n < 20);
    chk({tag, ".req"}, {31'h0, mem_req}, 32'h1);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ope_valid && n < 60);
    chk({tag, ".vld"}, {31'h0, ope_valid}, 32'h1);
  endtask

  task automatic pulse_ready();
    ope_ready = 1'b1;
    @(negedge clock);
    ope_ready = 1'b0;
  endtask

  logic [7:0] ops [15] = '{8'h55, 8'h50, 8'h53, 8'h5d, 8'hc3, 8'hc9, 8'h89, 8'h01,
                           8'h6a, 8'h75, 8'heb, 8'h8b, 8'h83, 8'hb8, 8'he8};

  initial begin
    int n, l, acc;
    logic [31:0] epc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    mem[0] = 8'h55;
    repeat (2) @(negedge clock);
    chk("rst.req", {31'h0, mem_req}, 32'h0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.ope", ope, 32'h0);
    chk("rst.num", {28'h0, num_of_ope}, 32'h0);
    chk("rst.iaddr", instr_addr, 32'h0);
    chk("rst.ill", {31'h0, illegal}, 32'h0);
    chk("rst.vld", {31'h0, ope_valid}, 32'h0);

    // 1-byte push, zero-wait: valid one cycle after the first request
    rst();
    wait_req("t1");
    wait_valid("t1", n);
    chk("t1.lat", 32'(n), 32'd1);
    expect_instr("t1", 32'h0, l);

    // 3-byte mov, next fetch at 3
    mem[0] = 8'h8b; mem[1] = 8'h45; mem[2] = 8'hfc;
    rst();
    wait_req("t2");
    wait_valid("t2", n);
    chk("t2.lat", 32'(n), 32'd3);
    expect_instr("t2", 32'h0, l);
    chk("t2.opeabs", ope, 32'h8b45fc00);
    pulse_ready();
    chk("t2.nreq", {31'h0, mem_req}, 32'h1);
    chk("t2.naddr", mem_addr, 32'h3);
    chk("t2.nvld", {31'h0, ope_valid}, 32'h0);

    // 5-byte call: byte 4 fetched and discarded
    mem[8'h10] = 8'he8; mem[8'h11] = 8'hee; mem[8'h12] = 8'hff;
    mem[8'h13] = 8'hff; mem[8'h14] = 8'hff;
    rst();
    goto(32'h10);
    wait_valid("t3", n);
    chk("t3.lat", 32'(n), 32'd5);
    expect_instr("t3", 32'h10, l);
    chk("t3.opeabs", ope, 32'he8eeffff);
    pulse_ready();
    chk("t3.naddr", mem_addr, 32'h15);

    // Slow memory: request held stable while waiting
    mem[8'h20] = 8'h6a; mem[8'h21] = 8'h04;
    mdelay = 3;
    rst();
    goto(32'h20);
    acc = 0;
    for (int i = 0; i < 40 && !ope_valid; i++) begin
      chk("t4.req", {31'h0, mem_req}, 32'h1);
      chk("t4.addr", mem_addr, 32'h20 + 32'(acc));
      if (mem_ack) acc++;
      @(negedge clock);
    end
    chk("t4.vld", {31'h0, ope_valid}, 32'h1);
    expect_instr("t4", 32'h20, l);
    chk("t4.opeabs", ope, 32'h6a040000);

    // Redirect while byte 2 of b8 is outstanding -> drain, no b8 delivery
    mem[8'h30] = 8'hb8; mem[8'h31] = 8'h01; mem[8'h32] = 8'h02;
    mem[8'h33] = 8'h03; mem[8'h34] = 8'h04; mem[8'h40] = 8'h55;
    mdelay = 2;
    rst();
    goto(32'h30);
    for (int i = 0; i < 30 && !(mem_req && mem_addr == 32'h32); i++) @(negedge clock);
    chk("t5.at2", mem_addr, 32'h32);
    chk("t5.noack", {31'h0, mem_ack}, 32'h0);
    goto(32'h40);
    chk("t5.drreq", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 20 && !mem_req; i++) begin
      chk("t5.novld", {31'h0, ope_valid}, 32'h0);
      @(negedge clock);
    end
    chk("t5.req", {31'h0, mem_req}, 32'h1);
    chk("t5.addr", mem_addr, 32'h40);
    wait_valid("t5", n);
    expect_instr("t5", 32'h40, l);

    // Illegal opcode at top of memory, held under back-pressure, pc wraps
    mdelay = 0;
    mem[8'hff] = 8'h90; mem[8'h00] = 8'h5d;
    rst();
    goto(32'hffff_ffff);
    wait_valid("t6", n);
    expect_instr("t6", 32'hffff_ffff, l);
    for (int i = 0; i < 5; i++) begin
      chk("t6.hvld", {31'h0, ope_valid}, 32'h1);
      chk("t6.hope", ope, 32'h9000_0000);
      chk("t6.hreq", {31'h0, mem_req}, 32'h0);
      @(negedge clock);
    end
    pulse_ready();
    chk("t6.wreq", {31'h0, mem_req}, 32'h1);
    chk("t6.waddr", mem_addr, 32'h0);
    wait_valid("t6b", n);
    expect_instr("t6b", 32'h0, l);

    // Reset in the middle of an outstanding read
    mdelay = 2;
    rst();
    goto(32'h10);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("t7.req", {31'h0, mem_req}, 32'h0);
    chk("t7.addr", mem_addr, 32'h0);
    chk("t7.vld", {31'h0, ope_valid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    mdelay = 0;
    wait_req("t7");
    chk("t7.raddr", mem_addr, 32'h0);
    wait_valid("t7", n);
    expect_instr("t7", 32'h0, l);

    // Random program, random latency, stalls and redirects
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 14)] : 8'($urandom);
    rst();
    epc = 32'h0;
    for (int t = 0; t < 80; t++) begin
      mdelay = $urandom_range(0, 2);
      wait_valid("rnd", n);
      expect_instr("rnd", epc, l);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if ($urandom_range(0, 4) == 0) begin
        ope_ready = 1'($urandom);
        epc = 32'($urandom_range(0, 511));
        goto(epc);
        ope_ready = 1'b0;
      end else begin
        pulse_ready();
        epc = epc + 32'(l);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
